// File: rtl/pc_branch_unit_pkg.sv
// pc_branch_unit_pkg: shared FSM state encodings and default parameters.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } pc_state_t;

  localparam int         PC_W_DEF     = 8;
  localparam logic [7:0] PC_RESET_DEF = 8'h00;

endpackage

// File: rtl/pc_branch_unit_branch_cond.sv
// branchCond: decides whether the decoded branch is taken.
// Latency: combinational.
// Backpressure: none.
// Ports: bcf/bbf/buc decoder flags, carryFlag/borrowFlag ALU flags -> take.
module branchCond (
  input  logic bcf,
  input  logic bbf,
  input  logic buc,
  input  logic carryFlag,
  input  logic borrowFlag,
  output logic take
);

  assign take = buc | (bcf & carryFlag) | (bbf & borrowFlag);

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, relative branch resolution, output-pin source select.
// Latency: step at edge N -> pc/outSelPc/branchTaken updated at edge N+1; outPins combinational.
// Backpressure: step is ignored (not queued) while busy; one instruction per 2 cycles max.
// Ports: clk, rst (async active-high), step, decoder flags bcf/bbf/buc/toggleOut,
//        ALU carryFlag/borrowFlag, r3Val offset -> pc, outSelPc, outPins, branchTaken, busy, halted.
// Build option: define PC_HALT_DETECT_EN to halt on a taken zero-offset branch.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int            PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            bcf,
  input  logic            bbf,
  input  logic            buc,
  input  logic            toggleOut,
  input  logic            carryFlag,
  input  logic            borrowFlag,
  input  logic [PC_W-1:0] r3Val,
  output logic [PC_W-1:0] pc,
  output logic            outSelPc,
  output logic [PC_W-1:0] outPins,
  output logic            branchTaken,
  output logic            busy,
  output logic            halted
);

  pc_state_t       state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            sel_nxt;
  logic            bt_nxt;
  logic            take;

  branchCond u_branch_cond (
    .bcf        (bcf),
    .bbf        (bbf),
    .buc        (buc),
    .carryFlag  (carryFlag),
    .borrowFlag (borrowFlag),
    .take       (take)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= PC_RESET;
      outSelPc    <= 1'b0;
      branchTaken <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outSelPc    <= sel_nxt;
      branchTaken <= bt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sel_nxt   = outSelPc;
    bt_nxt    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (step) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        // A taken branch owns the PC even when toggleOut is also set.
        if (take) begin
          pc_nxt = pc + r3Val;
          bt_nxt = 1'b1;
`ifdef PC_HALT_DETECT_EN
          // Zero offset is a self-loop: park the machine instead of spinning.
          if (r3Val == '0) state_nxt = ST_HALT;
`endif
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
        if (toggleOut) sel_nxt = ~outSelPc;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  assign outPins = outSelPc ? pc : r3Val;
  assign busy    = (state != ST_FETCH);

`ifdef PC_HALT_DETECT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic       bcf, bbf, buc, toggleOut, carryFlag, borrowFlag;
  logic [7:0] r3Val;
  logic [7:0] pc;
  logic       outSelPc;
  logic [7:0] outPins;
  logic       branchTaken;
  logic       busy;
  logic       halted;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .bcf         (bcf),
    .bbf         (bbf),
    .buc         (buc),
    .toggleOut   (toggleOut),
    .carryFlag   (carryFlag),
    .borrowFlag  (borrowFlag),
    .r3Val       (r3Val),
    .pc          (pc),
    .outSelPc    (outSelPc),
    .outPins     (outPins),
    .branchTaken (branchTaken),
    .busy        (busy),
    .halted      (halted)
  );

  typedef struct {
    logic       bcf, bbf, buc, tog, carry, borrow;
    logic [7:0] r3;
    logic [7:0] exp_pc;
    logic       exp_sel;
    logic       exp_bt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bcf = v.bcf; bbf = v.bbf; buc = v.buc; toggleOut = v.tog;
    carryFlag = v.carry; borrowFlag = v.borrow; r3Val = v.r3;
  endtask

  task automatic clear_flags();
    bcf = 0; bbf = 0; buc = 0; toggleOut = 0; carryFlag = 0; borrowFlag = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    step = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_exec", idx), busy, 1);
    @(negedge clk);
    step = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d sel", idx), outSelPc, v.exp_sel);
    chk($sformatf("v%0d bt", idx), branchTaken, v.exp_bt);
    chk($sformatf("v%0d busy_done", idx), busy, 0);
    chk($sformatf("v%0d pins", idx), outPins, v.exp_sel ? v.exp_pc : v.r3);
    @(posedge clk); #1;
    chk($sformatf("v%0d bt_clear", idx), branchTaken, 0);
    @(negedge clk);
    clear_flags();
  endtask

  initial begin
    //            bcf bbf buc tog car bor r3     pc     sel bt
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 8'h10, 8'h10, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 8'h33, 8'h11, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 8'h0F, 8'h20, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 1, 0, 8'hFE, 8'h1E, 0, 1};
    vecs[4]  = '{0, 0, 1, 0, 0, 0, 8'h02, 8'h20, 0, 1};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 8'hFE, 8'h21, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 1, 8'hDF, 8'h00, 0, 1};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 8'hA5, 8'h00, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 1};
    vecs[10] = '{0, 0, 1, 0, 0, 0, 8'h20, 8'h10, 0, 1};
    vecs[11] = '{0, 0, 0, 1, 0, 0, 8'h55, 8'h11, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 8'h66, 8'h12, 0, 0};
    vecs[13] = '{1, 0, 0, 1, 1, 0, 8'h04, 8'h16, 1, 1};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 8'h77, 8'h17, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 1, 0, 8'h40, 8'h18, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 1, 8'h40, 8'h19, 0, 0};

    rst = 1'b1; step = 1'b0; r3Val = 8'h5A;
    clear_flags();
    repeat (3) @(posedge clk);
    #1;
    chk("rst pc", pc, 8'h00);
    chk("rst sel", outSelPc, 0);
    chk("rst pins", outPins, 8'h5A);
    chk("rst busy", busy, 0);
    chk("rst bt", branchTaken, 0);
    chk("rst halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle pc", pc, 8'h00);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // step held high: one instruction every two cycles, pc 19 -> 1A -> 1B
    @(negedge clk);
    r3Val = 8'h00;
    step = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("hold pc1", pc, 8'h1A);
    chk("hold busy1", busy, 0);
    @(posedge clk); #1;
    chk("hold busy2", busy, 1);
    chk("hold pc_mid", pc, 8'h1A);
    @(posedge clk); #1;
    chk("hold pc2", pc, 8'h1B);
    @(negedge clk);
    step = 1'b0;

    // zero-offset unconditional branch
    @(negedge clk);
    buc = 1'b1; r3Val = 8'h00; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(posedge clk); #1;
    chk("zero pc", pc, 8'h1B);
    chk("zero bt", branchTaken, 1);
`ifdef PC_HALT_DETECT_EN
    chk("zero halted", halted, 1);
    chk("zero busy", busy, 1);
    @(negedge clk);
    buc = 1'b1; toggleOut = 1'b1; r3Val = 8'h05; step = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("halt pc", pc, 8'h1B);
    chk("halt sel", outSelPc, 0);
    chk("halt still", halted, 1);
    chk("halt bt", branchTaken, 0);
    @(negedge clk);
    step = 1'b0; clear_flags();
    rst = 1'b1;
    #1 chk("halt rst halted", halted, 0);
    chk("halt rst pc", pc, 8'h00);
    chk("halt rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    buc = 1'b1; r3Val = 8'h1B; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(posedge clk); #1;
    chk("rejoin pc", pc, 8'h1B);
`else
    chk("zero halted", halted, 0);
    chk("zero busy", busy, 0);
    @(posedge clk); #1;
    chk("zero bt_clear", branchTaken, 0);
`endif
    @(negedge clk);
    clear_flags();

    // reset asserted mid-EXEC aborts the update
    @(negedge clk);
    buc = 1'b1; r3Val = 8'h40; step = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", busy, 1);
    rst = 1'b1;
    step = 1'b0;
    #1 chk("abort pc", pc, 8'h00);
    chk("abort busy_rst", busy, 0);
    @(posedge clk); #1;
    chk("abort pc2", pc, 8'h00);
    chk("abort bt", branchTaken, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_flags();
    @(posedge clk); #1;
    chk("abort idle busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
